// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic demand sequencer and the downstream light controller:
// sequencer state encoding, default timing constants and the round-robin road pick.
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_RUN      = 2'd3
    } state_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
    localparam int unsigned DEF_TICK_DIV        = 10;
    localparam int unsigned DEF_ACK_TIMEOUT     = 8;
    localparam int unsigned DEF_IDLE_TICKS      = 12;

    // Road to grant next: the single pending road, or the one not served last on a tie.
    function automatic logic pick_road(input logic p1, input logic p2, input logic last_served);
        if (p1 && p2) begin
            return ~last_served;
        end
        return p2;
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer plus counting debouncer for one raw vehicle sensor;
// emits a one-cycle pulse on each accepted 0->1 transition of the debounced level.
module sensor_debounce
    import traffic_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic sensor_in,
    output logic rise
);

    localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_CYCLES - 1);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       level_q, level_d;
    logic       rise_q, rise_d;
    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = sensor_in;
        sync2_d = sync1_q;
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_d   = '0;
        // Count only an unbroken run of mismatches; the last one flips the level.
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/traffic_demand_sequencer.sv
// Latches debounced road demand and issues start pulses to the light controller with
// round-robin road selection. Define TRAFFIC_DEMAND_FREERUN_EN for the idle free-run start.
module traffic_demand_sequencer
    import traffic_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned TICK_DIV        = DEF_TICK_DIV,
    parameter int unsigned ACK_TIMEOUT     = DEF_ACK_TIMEOUT,
    parameter int unsigned IDLE_TICKS      = DEF_IDLE_TICKS
) (
    input  logic clk,
    input  logic rst,
    input  logic sensor1,
    input  logic sensor2,
    input  logic ctrl_busy,
    output logic start_trafic,
    output logic dir_sel,
    output logic tick,
    output logic pend1,
    output logic pend2
);

    localparam logic [7:0] PRESC_LAST = 8'(TICK_DIV - 1);
    localparam logic [3:0] ACK_LAST   = 4'(ACK_TIMEOUT - 1);

    logic       rise1, rise2;
    state_t     state_q, state_d;
    logic       dir_sel_q, dir_sel_d;
    logic       last_served_q, last_served_d;
    logic       pend1_q, pend1_d;
    logic       pend2_q, pend2_d;
    logic [7:0] presc_q, presc_d;
    logic       tick_q, tick_d;
    logic [3:0] to_cnt_q, to_cnt_d;
    logic       serve_done;
`ifdef TRAFFIC_DEMAND_FREERUN_EN
    localparam logic [7:0] IDLE_LAST = 8'(IDLE_TICKS);
    logic [7:0] idle_cnt_q, idle_cnt_d;
`endif

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb1 (
        .clk       (clk),
        .rst       (rst),
        .sensor_in (sensor1),
        .rise      (rise1)
    );

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb2 (
        .clk       (clk),
        .rst       (rst),
        .sensor_in (sensor2),
        .rise      (rise2)
    );

    always_comb begin
        tick_d  = (presc_q == PRESC_LAST);
        presc_d = tick_d ? '0 : presc_q + 8'd1;
    end

    always_comb begin
        state_d       = state_q;
        dir_sel_d     = dir_sel_q;
        last_served_d = last_served_q;
        to_cnt_d      = '0;
        serve_done    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pend1_q || pend2_q) begin
                    state_d   = ST_ISSUE;
                    dir_sel_d = pick_road(pend1_q, pend2_q, last_served_q);
                end
`ifdef TRAFFIC_DEMAND_FREERUN_EN
                else if (idle_cnt_q == IDLE_LAST) begin
                    state_d   = ST_ISSUE;
                    dir_sel_d = ~last_served_q;
                end
`endif
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (ctrl_busy) begin
                    state_d = ST_RUN;
                end else if (to_cnt_q == ACK_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 4'd1;
                end
            end
            ST_RUN: begin
                if (!ctrl_busy) begin
                    state_d       = ST_IDLE;
                    last_served_d = dir_sel_q;
                    serve_done    = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A new rise in the same cycle as the serve-clear keeps the demand.
        pend1_d = rise1 | (pend1_q & ~(serve_done & ~dir_sel_q));
        pend2_d = rise2 | (pend2_q & ~(serve_done & dir_sel_q));
    end

`ifdef TRAFFIC_DEMAND_FREERUN_EN
    always_comb begin
        idle_cnt_d = '0;
        if (state_q == ST_IDLE && !pend1_q && !pend2_q && !rise1 && !rise2) begin
            idle_cnt_d = tick_q ? idle_cnt_q + 8'd1 : idle_cnt_q;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            dir_sel_q     <= 1'b0;
            last_served_q <= 1'b1;
            pend1_q       <= 1'b0;
            pend2_q       <= 1'b0;
            presc_q       <= '0;
            tick_q        <= 1'b0;
            to_cnt_q      <= '0;
`ifdef TRAFFIC_DEMAND_FREERUN_EN
            idle_cnt_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            dir_sel_q     <= dir_sel_d;
            last_served_q <= last_served_d;
            pend1_q       <= pend1_d;
            pend2_q       <= pend2_d;
            presc_q       <= presc_d;
            tick_q        <= tick_d;
            to_cnt_q      <= to_cnt_d;
`ifdef TRAFFIC_DEMAND_FREERUN_EN
            idle_cnt_q    <= idle_cnt_d;
`endif
        end
    end

    assign start_trafic = (state_q == ST_ISSUE);
    assign dir_sel      = dir_sel_q;
    assign tick         = tick_q;
    assign pend1        = pend1_q;
    assign pend2        = pend2_q;

endmodule

// File: tb/tb_traffic_demand_sequencer.sv
// Scoreboard bench for traffic_demand_sequencer (default build): randomized sensor and
// busy stimulus, expected start directions queued from a road-level demand model.
`timescale 1ns/1ps
module tb_traffic_demand_sequencer;

    localparam int unsigned DEB  = 4;
    localparam int unsigned TDIV = 10;
    localparam int unsigned ACK  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sensor1 = 1'b0;
    logic sensor2 = 1'b0;
    logic ctrl_busy = 1'b0;
    logic start_trafic, dir_sel, tick, pend1, pend2;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    int unsigned cyc = 0;
    int unsigned start_cnt = 0;
    int unsigned starts_consumed = 0;
    int unsigned start_cycles[$];
    bit          exp_q[$];
    bit          prev_start = 1'b0;

    // Road-level model: which roads hold demand, who was served last, who is granted now.
    bit m_pend[2];
    bit m_last = 1'b1;
    bit m_cur  = 1'b0;

    traffic_demand_sequencer #(
        .DEBOUNCE_CYCLES (DEB),
        .TICK_DIV        (TDIV),
        .ACK_TIMEOUT     (ACK),
        .IDLE_TICKS      (12)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sensor1      (sensor1),
        .sensor2      (sensor2),
        .ctrl_busy    (ctrl_busy),
        .start_trafic (start_trafic),
        .dir_sel      (dir_sel),
        .tick         (tick),
        .pend1        (pend1),
        .pend2        (pend2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every start pulse is checked against the head of the expectation queue.
    always @(negedge clk) begin
        if (rst) begin
            prev_start <= 1'b0;
        end else begin
            if (start_trafic) begin
                start_cnt++;
                start_cycles.push_back(cyc);
                check("start_not_consecutive", {31'd0, prev_start}, 32'd0);
                check("start_not_while_busy", {31'd0, ctrl_busy}, 32'd0);
                if (exp_q.size() == 0) check("unexpected_start", 32'd1, 32'd0);
                else check("start_dir_sel", {31'd0, dir_sel}, {31'd0, exp_q.pop_front()});
            end
            prev_start <= start_trafic;
        end
    end

    task automatic step(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    function automatic bit pick();
        if (m_pend[0] && m_pend[1]) return ~m_last;
        return m_pend[1];
    endfunction

    task automatic model_expect();
        m_cur = pick();
        exp_q.push_back(m_cur);
    endtask

    task automatic demand(input bit r1, input bit r2, input int unsigned len, input bit idle);
        if (len >= DEB) begin
            if (r1) m_pend[0] = 1'b1;
            if (r2) m_pend[1] = 1'b1;
            if (idle) model_expect();
        end
        sensor1 = r1;
        sensor2 = r2;
        step(len);
        sensor1 = 1'b0;
        sensor2 = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        starts_consumed++;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (start_cnt >= starts_consumed) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("start_within_bound", {31'd0, ok}, 32'd1);
    endtask

    task automatic check_pends(input string name);
        check({name, "_pend1"}, {31'd0, pend1}, {31'd0, m_pend[0]});
        check({name, "_pend2"}, {31'd0, pend2}, {31'd0, m_pend[1]});
    endtask

    // Grant the current start with a busy window; optionally raise the other road mid-run.
    task automatic serve(input bit need_wait, input bit do_mid, input int unsigned busy_len);
        bit ok;
        bit d;
        if (need_wait) wait_start(ok);
        d = m_cur;
        step($urandom_range(1, 3));
        ctrl_busy = 1'b1;
        if (do_mid) begin
            step(1);
            demand(d, ~d, 8, 1'b0);
            step($urandom_range(1, 6));
            check("mid_run_demand_latched", {31'd0, (d ? pend1 : pend2)}, 32'd1);
        end else begin
            step(busy_len);
        end
        m_pend[d] = 1'b0;
        m_last = d;
        if (m_pend[0] || m_pend[1]) model_expect();
        ctrl_busy = 1'b0;
        step(3);
        check_pends("after_run");
    endtask

    task automatic timeout_case(input bit r);
        bit ok;
        demand(~r, r, $urandom_range(5, 10), 1'b1);
        wait_start(ok);
        model_expect();
        wait_start(ok);
        if (start_cycles.size() >= 2)
            check("timeout_restart_gap", start_cycles[$] - start_cycles[$-1], ACK + 2);
        check_pends("after_timeout");
        serve(1'b0, 1'b0, $urandom_range(1, 20));
    endtask

    initial begin
        bit ok;
        bit r;
        m_pend[0] = 1'b0;
        m_pend[1] = 1'b0;

        step(3);
        check("reset_start", {31'd0, start_trafic}, 32'd0);
        check("reset_dir_sel", {31'd0, dir_sel}, 32'd0);
        check("reset_tick", {31'd0, tick}, 32'd0);
        check_pends("reset");
        rst = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            check("tick_phase", {31'd0, tick}, {31'd0, ((i % TDIV) == 0)});
        end

        demand(1'b1, 1'b0, 2, 1'b1);
        step(30);
        check_pends("short_pulse");
        for (int i = 0; i < 3; i++) begin
            r = 1'($urandom_range(0, 1));
            demand(~r, r, $urandom_range(1, DEB - 1), 1'b1);
            step(12);
            check_pends("glitch");
        end

        demand(1'b1, 1'b0, 10, 1'b1);
        serve(1'b1, 1'b0, 20);
        step(8);

        demand(1'b1, 1'b1, 6, 1'b1);
        serve(1'b1, 1'b0, $urandom_range(1, 20));
        serve(1'b1, 1'b0, $urandom_range(1, 20));
        step(8);

        timeout_case(1'b0);
        step(8);

        for (int it = 0; it < 14; it++) begin
            r = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0: begin
                    demand(~r, r, $urandom_range(5, 10), 1'b1);
                    serve(1'b1, 1'b0, $urandom_range(1, 20));
                end
                1: begin
                    demand(1'b1, 1'b1, $urandom_range(5, 10), 1'b1);
                    serve(1'b1, 1'b0, $urandom_range(1, 20));
                    serve(1'b1, 1'b0, $urandom_range(1, 20));
                end
                2: timeout_case(r);
                3: begin
                    demand(~r, r, $urandom_range(5, 10), 1'b1);
                    serve(1'b1, 1'b1, 0);
                    serve(1'b1, 1'b0, $urandom_range(1, 20));
                end
                default: begin
                    demand(~r, r, $urandom_range(1, DEB - 1), 1'b1);
                    step(15);
                    check_pends("rand_glitch");
                end
            endcase
            step(8);
        end

        // Reset while the controller is running: everything drops and no start follows.
        demand(1'b0, 1'b1, 7, 1'b1);
        wait_start(ok);
        step(2);
        ctrl_busy = 1'b1;
        step(4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        ctrl_busy = 1'b0;
        m_pend[0] = 1'b0;
        m_pend[1] = 1'b0;
        m_last = 1'b1;
        check("rst_run_start", {31'd0, start_trafic}, 32'd0);
        check("rst_run_dir_sel", {31'd0, dir_sel}, 32'd0);
        check("rst_run_tick", {31'd0, tick}, 32'd0);
        check_pends("rst_run");
        step(40);
        check_pends("post_reset");

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

endmodule
